// File: rtl/mmio_fifo_pkg.sv
// Shared constants for the MMIO FIFO controller.
// This file holds the register offsets and the bit positions inside the STATUS and CTRL registers.
package mmio_fifo_pkg;

    // Register offsets relative to BASE_ADDR (CCI-P word addresses)
    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_PEEK   = 3'd6;

    // Highest in-window offset
    localparam logic [15:0] WIN_LAST_OFF = 16'd6;

    // STATUS layout: [15:0] occupancy, then single-bit flags
    localparam int ST_EMPTY_BIT = 16;
    localparam int ST_FULL_BIT  = 17;
    localparam int ST_OVF_BIT   = 18;
    localparam int ST_UDF_BIT   = 19;

    // CTRL layout
    localparam int CTRL_FLUSH_BIT = 0;
    localparam int CTRL_CLR_BIT   = 1;

endpackage

// File: rtl/mmio_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array.
// It has one synchronous write port and one combinational read port. Contents are deliberately not reset.
module mmio_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the pushed word at the tail slot
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-mapped FIFO controller.
// It decodes host MMIO accesses in a 7-word window into push, pop, peek, status and control operations.
// It also owns the pointers, the occupancy count and the sticky error flags.
//
// Response handshake: there is no ready and no backpressure. rd_rsp_valid is a single-cycle pulse.
// The pulse is registered from an in-window mmio_rd_valid in the previous cycle.
// rd_rsp_tid and rd_rsp_data are only meaningful while rd_rsp_valid is high.
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          WIDTH     = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0020
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mmio_wr_valid,
    input  logic                     mmio_rd_valid,
    input  logic [15:0]              mmio_addr,
    input  logic [8:0]               mmio_tid,
    input  logic [WIDTH-1:0]         mmio_wdata,
    output logic                     rd_rsp_valid,
    output logic [8:0]               rd_rsp_tid,
    output logic [WIDTH-1:0]         rd_rsp_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             rsp_valid_q;
    logic [8:0]       rsp_tid_q;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] head_data;
    logic [WIDTH-1:0] status_w;

    // Address decode: the window check is done on the full 16-bit offset so aliases outside are rejected
    logic [15:0] addr_off;
    logic [2:0]  off;
    logic        in_win;
    logic        rd_hit, pop_req, push_req, ctrl_wr, flush, clr_sticky;
    logic        pop_ok, push_ok, ovf_evt, udf_evt;

    assign addr_off = mmio_addr - BASE_ADDR;
    assign in_win   = (mmio_addr >= BASE_ADDR) && (addr_off <= WIN_LAST_OFF);
    assign off      = addr_off[2:0];

    assign rd_hit     = mmio_rd_valid && in_win;
    assign pop_req    = rd_hit && (off == OFF_DATA);
    assign push_req   = mmio_wr_valid && in_win && (off == OFF_DATA);
    assign ctrl_wr    = mmio_wr_valid && in_win && (off == OFF_CTRL);
    assign flush      = ctrl_wr && mmio_wdata[CTRL_FLUSH_BIT];
    assign clr_sticky = ctrl_wr && mmio_wdata[CTRL_CLR_BIT];

    // Flush overrides a same-cycle pop; a pop frees a slot so a push on a full FIFO still lands
    assign pop_ok  = pop_req && !empty_q && !flush;
    assign udf_evt = pop_req && empty_q && !flush;
    assign push_ok = push_req && !flush && (!full_q || pop_ok);
    assign ovf_evt = push_req && !flush && full_q && !pop_ok;

    mmio_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (tail_q),
        .wdata_i (mmio_wdata),
        .raddr_i (head_q),
        .rdata_o (head_data)
    );

    // Next pointer, count and sticky-flag values; a new event beats a same-cycle clear
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_ok)  head_d = head_q + AW'(1);
            if (push_ok) tail_d = tail_q + AW'(1);
            if (push_ok && !pop_ok) count_d = count_q + CW'(1);
            if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
        if (clr_sticky) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (ovf_evt) ovf_d = 1'b1;
        if (udf_evt) udf_d = 1'b1;
    end

    // STATUS image built from the current registered state
    always_comb begin
        status_w               = '0;
        status_w[15:0]         = 16'(count_q);
        status_w[ST_EMPTY_BIT] = empty_q;
        status_w[ST_FULL_BIT]  = full_q;
        status_w[ST_OVF_BIT]   = ovf_q;
        status_w[ST_UDF_BIT]   = udf_q;
    end

    // Read data mux; odd offsets, CTRL and underflowing or flushed pops all return zero
    always_comb begin
        rsp_data_d = '0;
        if (rd_hit) begin
            case (off)
                OFF_DATA:   if (pop_ok) rsp_data_d = head_data;
                OFF_STATUS: rsp_data_d = status_w;
                OFF_PEEK:   if (!empty_q) rsp_data_d = head_data;
                default:    rsp_data_d = '0;
            endcase
        end
    end

    // FIFO bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Read response register: one pulse per in-window read, TID echoed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rd_hit;
            if (rd_hit) begin
                rsp_tid_q  <= mmio_tid;
                rsp_data_q <= rsp_data_d;
            end
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_tid   = rsp_tid_q;
    assign rd_rsp_data  = rsp_data_q;
    assign fifo_count   = count_q;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;

endmodule
